// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: channel indices,
// routing-mode encodings and default parameter values.
package demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam logic MODE_SEL = 1'b0;  // route by in_sel
  localparam logic MODE_TDM = 1'b1;  // alternate ch0/ch1 via rr_ptr

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. The head word is presented
// combinationally; data reads as zero while empty so a flushed channel
// shows a clean bus.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full when the index bits match but the wrap bits differ.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer registers; async reset discards any buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each accepted input word is
// steered to one of two channel FIFOs, either by in_sel or by an
// alternating time-division pointer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on registered FIFO state and the routing
// inputs (mode, in_sel, rr_ptr), never on out*_ready, so there is no
// combinational path from the consumers back to the producer.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             rr_ptr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic tgt;
  logic accept;
  logic push0, push1;
  logic full0, full1;
  logic empty0, empty1;

  // Routing: pick the target channel and gate acceptance on its FIFO only.
  always_comb begin
    tgt      = (mode == MODE_TDM) ? rr_ptr : in_sel;
    in_ready = (tgt == CH0) ? !full0 : !full1;
    accept   = in_valid && in_ready;
    push0    = accept && (tgt == CH0);
    push1    = accept && (tgt == CH1);
  end

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .push    (push0),
    .wr_data (in_data),
    .pop     (out0_ready),
    .rd_data (out0_data),
    .full    (full0),
    .empty   (empty0)
  );

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .push    (push1),
    .wr_data (in_data),
    .pop     (out1_ready),
    .rd_data (out1_data),
    .full    (full1),
    .empty   (empty1)
  );

  // Channel valids are simply FIFO non-empty.
  always_comb begin
    out0_valid = !empty0;
    out1_valid = !empty1;
  end

  // Time-division pointer: held at ch0 in select mode, toggles per accept in TDM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= CH0;
    end else if (mode == MODE_SEL) begin
      rr_ptr <= CH0;
    end else if (accept) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  // Per-channel accepted-word counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + CNT_ONE;
      if (push1) cnt1 <= cnt1 + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Directed bench for demux_1x2_stream (DEPTH=2, CNT_W=4 so counter wrap is reachable).
module tb_demux_1x2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             mode;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             rr_ptr;

  int tests_run = 0;
  int failed    = 0;

  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];

  demux_1x2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .rr_ptr     (rr_ptr)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; inputs are then driven and outputs sampled 2ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_sel = 1'b0; in_valid = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    tests_run++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b/%b want 0/0", out0_valid, out1_valid); end
    tests_run++; if (out0_data !== 8'h00 || out1_data !== 8'h00) begin failed++; $display("FAIL reset_data: got %h/%h want 00/00", out0_data, out1_data); end
    tests_run++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || rr_ptr !== 1'b0) begin failed++; $display("FAIL reset_cnt: got %0d/%0d/%b want 0/0/0", cnt0, cnt1, rr_ptr); end
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
    // Two words into ch0 with the consumer stalled, then reset mid-cycle.
    in_valid = 1'b1; in_data = 8'hE1; step();
    in_data = 8'hE2; step();
    in_valid = 1'b0;
    #1;
    tests_run++; if (out0_valid !== 1'b1 || cnt0 !== 4'd2) begin failed++; $display("FAIL prereset_fill: got valid %b cnt0 %0d want 1/2", out0_valid, cnt0); end
    rst = 1'b1;
    #1;
    tests_run++; if (out0_valid !== 1'b0 || cnt0 !== 4'd0 || in_ready !== 1'b1) begin failed++; $display("FAIL async_flush: got valid %b cnt0 %0d ready %b want 0/0/1", out0_valid, cnt0, in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_select();
    mode = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA1; in_sel = 1'b0; step();
    in_data = 8'hB2; in_sel = 1'b1;
    tests_run++; if (out0_valid !== 1'b1 || out0_data !== 8'hA1) begin failed++; $display("FAIL sel_ch0_first: got %b/%h want 1/a1", out0_valid, out0_data); end
    step();
    in_data = 8'hC3; in_sel = 1'b0;
    tests_run++; if (out1_valid !== 1'b1 || out1_data !== 8'hB2 || out0_valid !== 1'b0) begin failed++; $display("FAIL sel_ch1: got %b/%h ch0v %b want 1/b2/0", out1_valid, out1_data, out0_valid); end
    step();
    in_valid = 1'b0;
    tests_run++; if (out0_valid !== 1'b1 || out0_data !== 8'hC3 || out1_valid !== 1'b0) begin failed++; $display("FAIL sel_ch0_second: got %b/%h ch1v %b want 1/c3/0", out0_valid, out0_data, out1_valid); end
    step();
    tests_run++; if (cnt0 !== 4'd2 || cnt1 !== 4'd1) begin failed++; $display("FAIL sel_counts: got %0d/%0d want 2/1", cnt0, cnt1); end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0; out1_ready = 1'b0; mode = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h31; step();
    in_data = 8'h32; step();
    in_data = 8'h33;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_ch0_full: got in_ready %b want 0", in_ready); end
    in_sel = 1'b1; in_data = 8'h55;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_ch1_open: got in_ready %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++; if (out1_valid !== 1'b1 || out1_data !== 8'h55 || out0_data !== 8'h31) begin failed++; $display("FAIL bp_ch1_word: got %b/%h ch0 %h want 1/55/31", out1_valid, out1_data, out0_data); end
  endtask

  task automatic test_full_pop();
    // ch0 holds 0x31,0x32 (full) from the previous task.
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h34;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin failed++; $display("FAIL fp_no_bypass: got in_ready %b want 0", in_ready); end
    step();
    tests_run++; if (out0_data !== 8'h32 || in_ready !== 1'b1) begin failed++; $display("FAIL fp_pop_only: got %h ready %b want 32/1", out0_data, in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++; if (out0_valid !== 1'b1 || out0_data !== 8'h34) begin failed++; $display("FAIL fp_order: got %b/%h want 1/34", out0_valid, out0_data); end
    out1_ready = 1'b1;
    step();
    tests_run++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== 4'd5) begin failed++; $display("FAIL fp_drained: got %b/%b cnt0 %0d want 0/0/5", out0_valid, out1_valid, cnt0); end
  endtask

  task automatic test_tdm();
    int idx = 0;
    int stall_left = 0;
    int stalls = 0;
    int cycles = 0;
    exp_q0 = '{8'h10, 8'h12, 8'h14};
    exp_q1 = '{8'h11, 8'h13, 8'h15};
    mode = 1'b1; out0_ready = 1'b1; in_sel = 1'b1;
    while ((idx < 6 || out0_valid || out1_valid) && cycles < 40) begin
      in_valid = (idx < 6);
      in_data = 8'(8'h10 + idx);
      out1_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (out0_valid && out0_ready) begin
        tests_run++;
        if (exp_q0.size() == 0) begin failed++; $display("FAIL tdm_ch0_extra: got %h want none", out0_data); end
        else if (out0_data !== exp_q0[0]) begin failed++; $display("FAIL tdm_ch0_data: got %h want %h", out0_data, exp_q0[0]); void'(exp_q0.pop_front()); end
        else void'(exp_q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        tests_run++;
        if (exp_q1.size() == 0) begin failed++; $display("FAIL tdm_ch1_extra: got %h want none", out1_data); end
        else if (out1_data !== exp_q1[0]) begin failed++; $display("FAIL tdm_ch1_data: got %h want %h", out1_data, exp_q1[0]); void'(exp_q1.pop_front()); end
        else void'(exp_q1.pop_front());
      end
      if (in_valid) begin
        tests_run++;
        if (rr_ptr !== 1'(idx % 2)) begin failed++; $display("FAIL tdm_rr_ptr: got %b want %0d at word %0d", rr_ptr, idx % 2, idx); end
        if (in_ready) begin
          if (idx == 1) stall_left = 3;
          idx++;
        end else begin
          stalls++;
        end
      end
      step();
      cycles++;
    end
    in_valid = 1'b0; out1_ready = 1'b1;
    tests_run++; if (cycles >= 40) begin failed++; $display("FAIL tdm_timeout: got %0d cycles want < 40", cycles); end
    tests_run++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin failed++; $display("FAIL tdm_missing: got %0d/%0d left want 0/0", exp_q0.size(), exp_q1.size()); end
    tests_run++; if (stalls != 1) begin failed++; $display("FAIL tdm_stall_cycles: got %0d want 1", stalls); end
    tests_run++; if (cnt0 !== 4'd3 || cnt1 !== 4'd3) begin failed++; $display("FAIL tdm_counts: got %0d/%0d want 3/3", cnt0, cnt1); end
  endtask

  task automatic test_wrap_mode();
    mode = 1'b0; in_sel = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = 8'(i);
      step();
    end
    tests_run++; if (cnt1 !== 4'd15) begin failed++; $display("FAIL wrap_pre: got %0d want 15", cnt1); end
    step();
    in_valid = 1'b0;
    tests_run++; if (cnt1 !== 4'd0 || cnt0 !== 4'd0) begin failed++; $display("FAIL wrap_zero: got cnt1 %0d cnt0 %0d want 0/0", cnt1, cnt0); end
    step();
    mode = 1'b1; in_valid = 1'b1; in_data = 8'h60; step();
    in_valid = 1'b0;
    tests_run++; if (rr_ptr !== 1'b1 || out0_data !== 8'h60) begin failed++; $display("FAIL tdm_first: got ptr %b data %h want 1/60", rr_ptr, out0_data); end
    mode = 1'b0; step();
    tests_run++; if (rr_ptr !== 1'b0) begin failed++; $display("FAIL mode_clear_ptr: got %b want 0", rr_ptr); end
    mode = 1'b1; in_valid = 1'b1; in_data = 8'h61; step();
    in_valid = 1'b0;
    tests_run++; if (out0_valid !== 1'b1 || out0_data !== 8'h61 || out1_valid !== 1'b0 || cnt0 !== 4'd2) begin failed++; $display("FAIL tdm_restart_ch0: got %b/%h ch1v %b cnt0 %0d want 1/61/0/2", out0_valid, out0_data, out1_valid, cnt0); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_full_pop();
    apply_reset();
    test_tdm();
    apply_reset();
    test_wrap_mode();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/demux_1x2_stream.md
# demux_1x2_stream

Registered 1-to-2 stream demultiplexer: the receive-side counterpart of `mux_2x1`. It takes one valid/ready input stream and steers each accepted word to one of two output channels. Routing comes from an explicit per-word select or, in time-division mode, from an internal alternating pointer; this undoes a stream built by a `mux_2x1` with a toggling select. Each output channel has its own small FIFO, so a stalled consumer on one channel does not block words bound for the other.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 2: entries per channel FIFO; power of two, ≥2.
- `CNT_W`, 16: width of the per-channel word counters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = route by `in_sel`; 1 = time-division, alternate ch0/ch1.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  target channel when `mode`=0; ignored when `mode`=1.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  the block accepts the word this cycle.
- `out0_data`, `out1_data`  out  WIDTH  head of channel FIFO.
- `out0_valid`, `out1_valid`  out  1  channel FIFO non-empty.
- `out0_ready`, `out1_ready`  in  1  consumer takes the head word.
- `cnt0`, `cnt1`  out  CNT_W  words accepted into each channel, wrapping.
- `rr_ptr`  out  1  next time-division target.

## Operation
- Target channel: `tgt = mode ? rr_ptr : in_sel`.
- `in_ready = !full[tgt]`. This is combinational from registered FIFO state and `mode`/`in_sel`/`rr_ptr` only, never from `out*_ready`.
- Accept: `in_valid & in_ready`. The word is pushed into FIFO[`tgt`], and `cnt[tgt]` increments modulo 2^CNT_W.
- Pop: `outN_valid & outN_ready` removes the head of FIFO N.
- Channels are independent. Push to one channel and pop from the other in the same cycle are both performed.
- Push and pop on the same channel in the same cycle:
  - FIFO not full: both performed, occupancy unchanged.
  - FIFO full: `in_ready` is 0, so only the pop happens. There is no bypass.
- `rr_ptr` toggles on each accept while `mode`=1.
- `rr_ptr` is forced to 0 on every cycle with `mode`=0, so entering mode 1 always starts at ch0.
- Mode may change on any cycle. Words already in the FIFOs are unaffected.
- Holding data while `in_valid`=1 and `in_ready`=0 is the upstream's obligation; the block does not check it.

## Timing
- Reset values: all `outN_valid`=0, `outN_data`=0, `cnt0`=`cnt1`=0, `rr_ptr`=0, FIFOs empty, so `in_ready`=1 with `rst` low.
- Reset asserted mid-operation flushes both FIFOs immediately (asynchronous). Buffered words are lost.
- Latency: a word accepted at edge k is visible on `outN_data`/`outN_valid` after edge k. This gives one cycle of latency from the accepting cycle to the first cycle it can be popped.
- Throughput: one word per cycle into either channel while its FIFO is not full.
- Back-pressure is per channel. A full ch0 with `mode`=0 and `in_sel`=1 still gives `in_ready`=1.
- In `mode`=1, a full target FIFO stalls the whole input. The pointer does not skip.
- Counter wrap: `cnt` at 2^CNT_W−1 plus one accept becomes 0. There is no saturation flag.

## Structure
- Shared package `demux_pkg`: `CH0`/`CH1` channel index constants, `MODE_SEL`/`MODE_TDM` constants, default `WIDTH`/`DEPTH`/`CNT_W`.
- One sub-module, `stream_fifo`:
  - parameterised WIDTH/DEPTH synchronous FIFO;
  - registered read/write pointers with an extra wrap bit;
  - `full`/`empty` outputs;
  - same `clk`/`rst` scheme.
- Top level instantiates `stream_fifo` twice and adds the routing logic, `rr_ptr` and counters.

## Test plan
- Reset: assert `rst` mid-stream with 2 words in ch0 → `out0_valid`=0, `cnt0`=0 and `in_ready`=1 immediately, before any clock edge.
- Select mode: send 0xA1(sel 0), 0xB2(sel 1), 0xC3(sel 0) with both readies high → ch0 outputs 0xA1 then 0xC3, ch1 outputs 0xB2; `cnt0`=2, `cnt1`=1.
- Per-channel back-pressure: `out0_ready`=0 and DEPTH=2:
  - 2 words to ch0 → `in_ready`=0 when `in_sel`=0.
  - Switch `in_sel`=1 → `in_ready`=1 and 0x55 reaches ch1.
- Full FIFO with pop: ch0 full, `out0_ready`=1 and `in_valid`=1 to ch0 → pop only that cycle; accept on the next cycle; order preserved.
- TDM mode: `mode`=1, stream 0x10..0x15 with ch1 stalled 3 cycles after the first ch1 word:
  - ch0 gets 0x10/0x12/0x14, ch1 gets 0x11/0x13/0x15.
  - No word is dropped or reordered, and `rr_ptr` does not advance while stalled.
- Counter wrap and mode switch: CNT_W=4, 16 accepts to ch1 → `cnt1`=0. Drop `mode` to 0 for one cycle, return to 1 → first word goes to ch0.
